// File: rtl/m_unit_ctrl.sv
// M-extension sequencer: one-shot multiply, 32-step restoring divide.
// Drives an external datapath through R/D/Z, mult_a/b and the div/rem mux.
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`define MUX_DIV_REM_R 1'b1
`define MUX_DIV_REM_Z 1'b0
`endif

module m_unit_ctrl (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2:0]                      funct3,
  input  logic [31:0]                     rs1,
  input  logic [31:0]                     rs2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     result,
  output logic [31:0]                     R,
  output logic [62:0]                     D,
  output logic [31:0]                     Z,
  output logic [`MUX_DIV_REM_LENGTH-1:0]  mux_div_rem,
  output logic signed [32:0]              mult_a,
  output logic signed [32:0]              mult_b,
  input  logic                            sub_neg,
  input  logic [31:0]                     sub_result,
  input  logic signed [65:0]              product,
  input  logic [31:0]                     div_rem,
  input  logic [31:0]                     div_rem_neg
);

  typedef enum logic [2:0] {
    IDLE, MUL, DIV, FIX, DONE
  } state_t;

  state_t     state;
  logic [2:0] op;
  logic       neg_q;
  logic       neg_r;
  logic [4:0] cnt;

  logic        div_sgn;
  logic        a_sext;
  logic        b_sext;
  logic [31:0] abs1;
  logic [31:0] abs2;

  // funct3[0]==0 marks the signed divide ops (DIV/REM)
  assign div_sgn = ~funct3[0];
  assign a_sext  = (funct3[1:0] == 2'b01) ||
                   (funct3[1:0] == 2'b10);
  assign b_sext  = (funct3[1:0] == 2'b01);
  assign abs1    = (div_sgn & rs1[31]) ? -rs1 : rs1;
  assign abs2    = (div_sgn & rs2[31]) ? -rs2 : rs2;

  logic unused_product;
  assign unused_product = ^product[65:64];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      R           <= '0;
      D           <= '0;
      Z           <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      cnt         <= '0;
      op          <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      mux_div_rem <= `MUX_DIV_REM_Z;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            op       <= funct3;
            neg_q    <= div_sgn & (rs1[31] ^ rs2[31]);
            neg_r    <= div_sgn & rs1[31];
            if (!funct3[2]) begin
              mult_a <= {a_sext & rs1[31], rs1};
              mult_b <= {b_sext & rs2[31], rs2};
              state  <= MUL;
            end else if (rs2 == 32'd0) begin
              result    <= funct3[1] ? rs1 : 32'hFFFF_FFFF;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              R     <= abs1;
              D     <= {abs2, 31'd0};
              Z     <= '0;
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        MUL: begin
          result    <= (op[1:0] == 2'b00) ?
                       product[31:0] : product[63:32];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DIV: begin
          if (!sub_neg) begin
            R <= sub_result;
            Z <= {Z[30:0], 1'b1};
          end else begin
            Z <= {Z[30:0], 1'b0};
          end
          D   <= D >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            mux_div_rem <= op[1] ? `MUX_DIV_REM_R
                                 : `MUX_DIV_REM_Z;
            state       <= FIX;
          end
        end
        FIX: begin
          result      <= (op[1] ? neg_r : neg_q) ?
                         div_rem_neg : div_rem;
          mux_div_rem <= `MUX_DIV_REM_Z;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_unit_ctrl.sv
// Directed bench for m_unit_ctrl with a behavioural M-unit datapath.
// Expected results are hand-computed constants.
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`define MUX_DIV_REM_R 1'b1
`define MUX_DIV_REM_Z 1'b0
`endif

module tb_m_unit_ctrl;

  logic                           clk = 1'b0;
  logic                           resetn;
  logic                           in_valid;
  logic                           in_ready;
  logic [2:0]                     funct3;
  logic [31:0]                    rs1;
  logic [31:0]                    rs2;
  logic                           out_valid;
  logic                           out_ready;
  logic [31:0]                    result;
  logic [31:0]                    R;
  logic [62:0]                    D;
  logic [31:0]                    Z;
  logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
  logic signed [32:0]             mult_a;
  logic signed [32:0]             mult_b;
  logic                           sub_neg;
  logic [31:0]                    sub_result;
  logic signed [65:0]             product;
  logic [31:0]                    div_rem;
  logic [31:0]                    div_rem_neg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  m_unit_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .R           (R),
    .D           (D),
    .Z           (Z),
    .mux_div_rem (mux_div_rem),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .sub_neg     (sub_neg),
    .sub_result  (sub_result),
    .product     (product),
    .div_rem     (div_rem),
    .div_rem_neg (div_rem_neg)
  );

  logic [63:0] diff;
  always_comb begin
    diff        = {32'd0, R} - {1'b0, D};
    sub_neg     = diff[63];
    sub_result  = diff[31:0];
    product     = 66'(mult_a) * 66'(mult_b);
    div_rem     = (mux_div_rem == `MUX_DIV_REM_R) ? R : Z;
    div_rem_neg = -div_rem;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int lat_exp);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    funct3   = f;
    rs1      = a;
    rs2      = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(lat_exp));
    chk({tag, ".res"}, 64'(result), 64'(exp));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    funct3    = '0;
    rs1       = '0;
    rs2       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.mux", 64'(mux_div_rem), 64'(`MUX_DIV_REM_Z));
    resetn = 1'b1;

    run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'd2,
           32'hFFFF_FFFF, 2);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'd2,
           32'h0000_0001, 2);
    run_op("mul",    3'b000, 32'h0001_0003, 32'hFFFF_FFFE,
           32'hFFFD_FFFA, 2);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 2);
    run_op("div",    3'b100, -32'sd7, 32'd2,
           32'hFFFF_FFFD, 34);
    run_op("rem",    3'b110, -32'sd7, 32'd2,
           32'hFFFF_FFFF, 34);
    run_op("divu0",  3'b101, 32'd100, 32'd0,
           32'hFFFF_FFFF, 1);
    run_op("remu0",  3'b111, 32'd100, 32'd0,
           32'd100, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 34);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 34);
    run_op("divu",   3'b101, 32'hFFFF_FFFF, 32'd16,
           32'h0FFF_FFFF, 34);
    run_op("remu",   3'b111, 32'd100, 32'd7,
           32'd2, 34);
    run_op("rem0",   3'b110, 32'h8000_0000, 32'd0,
           32'h8000_0000, 1);

    // backpressure: hold out_ready low with a pending request
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = 3'b101;
    rs1      = 32'd100;
    rs2      = 32'd7;
    @(posedge clk);
    #1 rs1 = 32'd3;
    funct3 = 3'b000;
    rs2    = 32'd4;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("bp.lat", 64'(lat), 64'd34);
    held = result;
    chk("bp.res", 64'(held), 64'd14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.hold", 64'(result), 64'd14);
      chk("bp.nordy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp.idle", 64'(in_ready), 64'd1);
    chk("bp.drop", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp.acc", 64'(in_ready), 64'd0);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("bp.next", 64'(result), 64'd12);
    chk("bp.nlat", 64'(lat), 64'd2);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = 3'b100;
    rs1      = 32'd1000;
    rs2      = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mr.ready", 64'(in_ready), 64'd1);
    chk("mr.valid", 64'(out_valid), 64'd0);
    chk("mr.R", 64'(R), 64'd0);
    chk("mr.D", 64'(D), 64'd0);
    chk("mr.Z", 64'(Z), 64'd0);
    chk("mr.ma", 64'(mult_a), 64'd0);
    chk("mr.mux", 64'(mux_div_rem), 64'(`MUX_DIV_REM_Z));
    @(posedge clk);
    #2 resetn = 1'b1;
    run_op("mr.mul", 3'b000, 32'd3, 32'd5, 32'd15, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_unit_ctrl.md
M_UNIT_CTRL -- requirements
Module: m_unit_ctrl

Interface
REQ-001 Parameters: none; the iteration count is fixed at 32 and the operand width at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  operation request.
REQ-005 in_ready  out  1  request accepted when in_valid & in_ready.
REQ-006 funct3  in  3  opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1, rs2  in  32 each  dividend/multiplicand, divisor/multiplier.
REQ-008 out_valid  out  1  result available; held until out_ready.
REQ-009 out_ready  in  1  result consumed when out_valid & out_ready.
REQ-010 result  out  32  operation result; stable while out_valid.
REQ-011 R  out  32;  D  out  63;  Z  out  32  remainder, shifted divisor and quotient registers, driven to the M-unit datapath.
REQ-012 mux_div_rem  out  `MUX_DIV_REM_LENGTH  selects MUX_DIV_REM_R or MUX_DIV_REM_Z at the datapath.
REQ-013 mult_a, mult_b  out  33 signed  extended multiply operands.
REQ-014 sub_neg  in  1;  sub_result  in  32  sign and low word of {31'b0,R} - D.
REQ-015 product  in  66 signed  mult_a * mult_b.
REQ-016 div_rem, div_rem_neg  in  32  selected R/Z and its two's complement.

Function
REQ-017 FSM states: IDLE, MUL, DIV, FIX, DONE; in_ready = 1 only in IDLE.
REQ-018 On acceptance, the block latches funct3, neg_q = signed op & rs1[31] ^ rs2[31], and neg_r = signed op & rs1[31].
REQ-019 MUL path: the block loads mult_a and mult_b with sign extension for signed operands (MULH: both; MULHSU: rs1 only) and zero extension otherwise, then enters MUL.
REQ-020 MUL state: result <= product[31:0] for MUL, or product[63:32] for the others; next state DONE.
REQ-021 DIV path, divisor nonzero: R <= |rs1| (magnitude for signed ops, raw value otherwise), D <= |rs2| << 31, Z <= 0, iteration counter <= 0, next state DIV.
REQ-022 DIV state, each cycle: if !sub_neg, then R <= sub_result and Z <= {Z[30:0],1}; otherwise Z <= {Z[30:0],0}. In both cases D <= D >> 1 and the counter increments. After the 32nd iteration the block enters FIX.
REQ-023 FIX state: mux_div_rem = Z for DIV/DIVU and R for REM/REMU; result <= div_rem_neg if (neg_q for DIV, neg_r for REM), else div_rem; next state DONE.
REQ-024 mux_div_rem holds MUX_DIV_REM_Z outside FIX.
REQ-025 Divide by zero: the block bypasses DIV/FIX, loads result <= 32'hFFFFFFFF for DIV/DIVU or rs1 for REM/REMU, and enters DONE directly.
REQ-026 Signed overflow (rs1 = 32'h80000000, rs2 = 32'hFFFFFFFF) needs no special case and yields quotient 32'h80000000, remainder 0.
REQ-027 DONE state: out_valid = 1; on out_ready the block returns to IDLE; a new request is accepted no earlier than the following cycle (no bypass).
REQ-028 Latency from the acceptance edge to out_valid: MUL ops 2 cycles; DIV/REM 34 cycles; divide-by-zero 1 cycle.
REQ-029 in_valid outside IDLE is ignored; operands and funct3 are not re-sampled mid-operation.
REQ-030 result, R, D, Z, mult_a and mult_b hold their values in all states except where REQ-019..025 update them.

Reset
REQ-031 While resetn = 0: state = IDLE, out_valid = 0, in_ready = 1, result, R, D, Z, mult_a, mult_b and counter = 0, mux_div_rem = MUX_DIV_REM_Z.
REQ-032 Reset asserted mid-operation aborts the operation with no output; after release the block accepts a new request in the first cycle.

Verification
REQ-033 MULH, rs1 = 32'hFFFFFFFF, rs2 = 32'h00000002 -> result 32'hFFFFFFFF, out_valid 2 cycles after acceptance; MULHU with the same operands -> 32'h00000001.
REQ-034 DIV, rs1 = -7, rs2 = 2 -> result 32'hFFFFFFFD after 34 cycles; REM with the same operands -> 32'hFFFFFFFF.
REQ-035 DIVU, rs1 = 100, rs2 = 0 -> 32'hFFFFFFFF after 1 cycle; REMU -> 100.
REQ-036 DIV, rs1 = 32'h80000000, rs2 = 32'hFFFFFFFF -> 32'h80000000; REM with the same operands -> 0.
REQ-037 out_ready held low for 5 cycles -> out_valid and result stable throughout; in_ready stays 0; the next request is accepted only after the handshake.
REQ-038 resetn pulsed low at DIV iteration 10 -> all outputs at their reset values; a following MUL of 3 * 5 -> 15.
